// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - load/store unit stage: EXE capture, single outstanding memory op, WB handoff
module lsu_stage #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exu_valid,
  output logic                lsu_ready_o,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [2:0]          load_type_i,
  input  logic [1:0]          store_type_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  output logic                mem_req_o,
  output logic                mem_wen_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [3:0]          mem_wstrb_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_LEN-1:0] mem_rdata_i,
  output logic                lsu_valid_o,
  input  logic                wb_ready,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic                misalign_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [2:0] LB  = 3'd1;
  localparam logic [2:0] LH  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [1:0] SB  = 2'd1;
  localparam logic [1:0] SH  = 2'd2;

  logic [1:0]          state;
  logic [2:0]          ltype_q;
  logic [1:0]          off_q;

  logic                is_load;
  logic                is_store;
  logic                mem_op;
  logic                size_b;
  logic                size_h;
  logic                mis;
  logic [1:0]          off;
  logic [3:0]          st_strb;
  logic [DATA_LEN-1:0] st_data;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [DATA_LEN-1:0] ld_data;

  assign lsu_ready_o = (state == IDLE);
  assign mem_req_o   = (state == REQ);
  assign lsu_valid_o = (state == DONE);
  assign off         = alu_result_i[1:0];

  // A load code wins over a simultaneous store code.
  always_comb begin
    is_load  = (load_type_i != 3'd0);
    is_store = !is_load && (store_type_i != 2'd0);
    mem_op   = is_load || is_store;
    size_b   = is_load ? (load_type_i == LB || load_type_i == LBU) : (store_type_i == SB);
    size_h   = is_load ? (load_type_i == LH || load_type_i == LHU) : (store_type_i == SH);
    mis      = mem_op && ((size_h && off[0]) || (!size_b && !size_h && off != 2'd0));
    st_strb  = 4'b1111;
    st_data  = mem_wdata_i;
    if (size_b) begin
      st_strb = 4'b0001 << off;
      st_data = {4{mem_wdata_i[7:0]}};
    end else if (size_h) begin
      st_strb = 4'b0011 << off;
      st_data = {2{mem_wdata_i[15:0]}};
    end
  end

  always_comb begin
    ld_byte = mem_rdata_i[7:0];
    case (off_q)
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      2'd3:    ld_byte = mem_rdata_i[31:24];
      default: ld_byte = mem_rdata_i[7:0];
    endcase
    ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (ltype_q)
      LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      LBU:     ld_data = {24'd0, ld_byte};
      LH:      ld_data = {{16{ld_half[15]}}, ld_half};
      LHU:     ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ltype_q     <= 3'd0;
      off_q       <= 2'd0;
      mem_wen_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= 4'd0;
      wd_o        <= 1'b0;
      wreg_o      <= 5'd0;
      wdata_o     <= '0;
      misalign_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (exu_valid) begin
          ltype_q     <= load_type_i;
          off_q       <= off;
          wreg_o      <= wreg_i;
          misalign_o  <= mis;
          mem_addr_o  <= {alu_result_i[ADDR_LEN-1:2], 2'b00};
          mem_wen_o   <= is_store && !mis;
          mem_wstrb_o <= (is_store && !mis) ? st_strb : 4'd0;
          mem_wdata_o <= (is_store && !mis) ? st_data : '0;
          wd_o        <= wd_i && !is_store && !mis;
          wdata_o     <= mem_op ? '0 : alu_result_i;
          state       <= (mem_op && !mis) ? REQ : DONE;
        end
        REQ: if (mem_gnt_i) state <= WAIT;
        WAIT: if (mem_rvalid_i) begin
          state <= DONE;
          if (ltype_q != 3'd0) wdata_o <= ld_data;
        end
        DONE: if (wb_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
